// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and keyboard command bytes.
package ps2_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK
  } ps2_tx_state_e;

  // Device clock falling edges in one host-to-device frame, the last one carrying the ACK.
  localparam int unsigned FRAME_FALLS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins plus clock falling-edge detect.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic dat_sync_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;

  // Reset to the idle-high bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_raw_i};
      dat_sync_q <= {dat_sync_q[0], dat_raw_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign dat_sync_o = dat_sync_q[1];
  assign fall_o     = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, start, 8 data bits LSB-first, odd parity, stop, ACK check.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts the frame when the device stops clocking.
module ps2_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [3:0]       bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             dat_sync;
  logic             fall;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .clk_raw_i  (ps2_clk_in),
    .dat_raw_i  (ps2_dat_in),
    .dat_sync_o (dat_sync),
    .fall_o     (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bits_q   <= '0;
      cnt_q    <= '0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      bits_q   <= bits_d;
      cnt_q    <= cnt_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    bits_d   = bits_q;
    cnt_d    = cnt_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          data_d  = tx_data;
          par_d   = ~^tx_data;
          bits_d  = '0;
          cnt_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START: state_d = ST_SEND;
      // Each device clock fall shifts the next bit onto DAT; the 10th releases it for the stop bit.
      ST_SEND: begin
        if (fall) begin
          bits_d = bits_q + 4'd1;
          if (bits_q < 4'd8) begin
            dat_oe_d = ~data_q[bits_q[2:0]];
          end else if (bits_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else if (bits_q == 4'(FRAME_FALLS - 2)) begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end
      // Stay one extra cycle so done/err is visible while still busy.
      ST_ACK: begin
        if (done_q || err_q) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          if (dat_sync) err_d = 1'b1;
          else          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if ((state_q == ST_START) || (state_q == ST_SEND) || (state_q == ST_ACK)) begin
      if (fall) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST) begin
        state_d  = ST_IDLE;
        dat_oe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_START);
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a PS/2 device model clocking at a 40-cycle period.
`timescale 1ns/1ps
module tb_ps2_tx;
  import ps2_defs::*;

  localparam int INH  = 10;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Open-drain bus: a line is low when either side pulls it.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte while IDLE; afterwards the bench sits in the first INHIBIT cycle.
  task automatic start_tx(input logic [7:0] b, input string nm);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept: got %b want 1", nm, tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    checks++;
    if ({tx_ready, busy, ps2_clk_oe} !== 3'b011) begin
      failures++;
      $display("FAIL %s accept: ready/busy/clk_oe got %b want 011", nm, {tx_ready, busy, ps2_clk_oe});
    end
  endtask

  // Count the clock-inhibit cycles, then check the single START cycle; exits in the first SEND cycle.
  task automatic phase_inhibit(input string nm, output int start_cyc);
    int n;
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < 100) begin
      n++;
      step(1);
    end
    checks++;
    if (n != INH) begin
      failures++;
      $display("FAIL %s inhibit_len: got %0d cycles want %0d", nm, n, INH);
    end
    start_cyc = cyc;
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin
      failures++;
      $display("FAIL %s start_cycle: clk_oe/dat_oe got %b want 11", nm, {ps2_clk_oe, ps2_dat_oe});
    end
    step(1);
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b01) begin
      failures++;
      $display("FAIL %s send_entry: clk_oe/dat_oe got %b want 01", nm, {ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  // Device model: samples DAT just before each rising edge; clock 11 carries the ACK when ack=1.
  task automatic device_frame(input int nclk, input bit ack, output logic [10:0] smp,
                              output int fall11_cyc, output logic oe2, output logic oe3);
    smp = '1;
    fall11_cyc = -1;
    oe2 = 1'b0;
    oe3 = 1'b0;
    step(HALF / 2);
    smp[0] = ps2_dat_in;
    for (int k = 1; k <= nclk && k <= 10; k++) begin
      dev_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        step(1);
        if (k == 1 && i == 2) oe2 = ps2_dat_oe;
        if (k == 1 && i == 3) oe3 = ps2_dat_oe;
      end
      smp[k] = ps2_dat_in;
      dev_clk = 1'b1;
      step(HALF);
    end
    if (nclk == 11) begin
      if (ack) dev_dat = 1'b0;
      step(5);
      dev_clk = 1'b0;
      fall11_cyc = cyc;
      step(HALF);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
    end
  endtask

  // Watches done/err until tx_ready returns; optionally injects a stray request and chains a new byte.
  task automatic monitor(input string nm, input bit inject, input bit chain, input logic [7:0] chain_b,
                         output int done_n, output int err_n, output int done_cyc,
                         output int err_cyc, output int ready_cyc);
    int sc;
    done_n = 0;
    err_n = 0;
    done_cyc = -1;
    err_cyc = -1;
    ready_cyc = -1;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (inject && i == 100) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      if (inject && i == 101) tx_valid = 1'b0;
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err === 1'b1) begin
        err_n++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (tx_ready === 1'b1 && (done_cyc >= 0 || err_cyc >= 0)) begin
        ready_cyc = cyc;
        break;
      end
    end
    if (chain && ready_cyc >= 0) begin
      tx_data  = chain_b;
      tx_valid = 1'b1;
      step(1);
      tx_valid = 1'b0;
      checks++;
      if ({tx_ready, ps2_clk_oe} !== 2'b01) begin
        failures++;
        $display("FAIL %s chain_accept: ready/clk_oe got %b want 01", nm, {tx_ready, ps2_clk_oe});
      end
      phase_inhibit({nm, "_chain"}, sc);
    end
  endtask

  // Runs one frame from the first SEND cycle and checks the wire bits and completion pulses.
  task automatic phase_frame(input string nm, input logic [7:0] b, input logic exp_par, input bit ack,
                             input bit inject, input bit chain, input logic [7:0] chain_b);
    logic [10:0] smp;
    logic        oe2, oe3;
    int          f11, dn, en, dc, ec, rc;
    fork
      device_frame(11, ack, smp, f11, oe2, oe3);
      monitor(nm, inject, chain, chain_b, dn, en, dc, ec, rc);
    join
    checks++;
    if (smp[0] !== 1'b0) begin
      failures++;
      $display("FAIL %s start_bit: got %b want 0", nm, smp[0]);
    end
    checks++;
    if (smp[8:1] !== b) begin
      failures++;
      $display("FAIL %s data_bits: got %02h want %02h", nm, smp[8:1], b);
    end
    checks++;
    if (smp[9] !== exp_par) begin
      failures++;
      $display("FAIL %s parity_bit: got %b want %b", nm, smp[9], exp_par);
    end
    checks++;
    if (smp[10] !== 1'b1) begin
      failures++;
      $display("FAIL %s stop_bit: got %b want 1", nm, smp[10]);
    end
    checks++;
    if ({oe2, oe3} !== {1'b1, ~b[0]}) begin
      failures++;
      $display("FAIL %s dat_oe_latency: oe at fall+2/+3 got %b want %b", nm, {oe2, oe3}, {1'b1, ~b[0]});
    end
    if (ack) begin
      checks++;
      if (dn != 1 || en != 0) begin
        failures++;
        $display("FAIL %s done_pulse: done cycles %0d err cycles %0d want 1 and 0", nm, dn, en);
      end
      checks++;
      if (dc != f11 + 3 || rc != dc + 1) begin
        failures++;
        $display("FAIL %s done_timing: done@%0d ready@%0d want %0d and %0d", nm, dc, rc, f11 + 3, f11 + 4);
      end
    end else begin
      checks++;
      if (en != 1 || dn != 0) begin
        failures++;
        $display("FAIL %s nack_pulse: err cycles %0d done cycles %0d want 1 and 0", nm, en, dn);
      end
      checks++;
      if (ec != f11 + 3 || rc != ec + 1) begin
        failures++;
        $display("FAIL %s nack_timing: err@%0d ready@%0d want %0d and %0d", nm, ec, rc, f11 + 3, f11 + 4);
      end
    end
    $display("tx %s byte=%02h wire=%02h par=%b stop=%b done=%0d err=%0d", nm, b, smp[8:1], smp[9], smp[10], dn, en);
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if ({tx_ready, busy, done, err, ps2_clk_oe, ps2_dat_oe} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_values: got %b want 100000", {tx_ready, busy, done, err, ps2_clk_oe, ps2_dat_oe});
    end
    rst = 1'b0;
    step(5);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 1000", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_send_ed();
    int sc;
    start_tx(CMD_SET_LEDS, "send_ed");
    phase_inhibit("send_ed", sc);
    phase_frame("send_ed", 8'hED, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(5);
  endtask

  task automatic test_send_zero();
    int sc;
    start_tx(8'h00, "send_00");
    phase_inhibit("send_00", sc);
    phase_frame("send_00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(5);
  endtask

  task automatic test_nack();
    int sc;
    start_tx(CMD_RESET, "nack_ff");
    phase_inhibit("nack_ff", sc);
    phase_frame("nack_ff", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(2);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
      failures++;
      $display("FAIL nack_idle: got %b want 1000", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
    end
    step(5);
  endtask

  task automatic test_no_device();
    int sc;
    int ec;
    int errs;
    start_tx(CMD_ENABLE, "no_dev");
    phase_inhibit("no_dev", sc);
`ifdef PS2_TX_TIMEOUT_EN
    ec = -1;
    for (int i = 0; i < 400 && ec < 0; i++) begin
      if (err === 1'b1) ec = cyc;
      else step(1);
    end
    checks++;
    if (ec - sc != TO) begin
      failures++;
      $display("FAIL timeout_delay: err %0d cycles after START want %0d", ec - sc, TO);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin
      failures++;
      $display("FAIL timeout_release: clk_oe/dat_oe/ready got %b want 001", {ps2_clk_oe, ps2_dat_oe, tx_ready});
    end
    step(1);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: err got %b want 0", err);
    end
    $display("tx no_dev byte=F4 timeout err_after=%0d", ec - sc);
`else
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (err === 1'b1 || done === 1'b1) errs++;
    end
    checks++;
    if (errs != 0 || {busy, ps2_dat_oe} !== 2'b11) begin
      failures++;
      $display("FAIL hang_no_watchdog: pulses %0d busy/dat_oe %b want 0 and 11", errs, {busy, ps2_dat_oe});
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    $display("tx no_dev byte=F4 hung until reset");
`endif
    step(5);
  endtask

  task automatic test_reset_mid_frame();
    int          sc;
    logic [10:0] smp;
    logic        o2, o3;
    int          f11;
    start_tx(CMD_ENABLE, "rst_mid");
    phase_inhibit("rst_mid", sc);
    device_frame(4, 1'b1, smp, f11, o2, o3);
    checks++;
    if ({busy, ps2_dat_oe} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_bit3: busy/dat_oe got %b want 11", {busy, ps2_dat_oe});
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready, done, err} !== 5'b00100) begin
      failures++;
      $display("FAIL rst_mid_abort: got %b want 00100", {ps2_clk_oe, ps2_dat_oe, tx_ready, done, err});
    end
    step(3);
    start_tx(CMD_ENABLE, "rst_f4");
    phase_inhibit("rst_f4", sc);
    phase_frame("rst_f4", 8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(5);
  endtask

  task automatic test_back_to_back();
    int sc;
    int stray;
    start_tx(CMD_SET_LEDS, "b2b_ed");
    phase_inhibit("b2b_ed", sc);
    phase_frame("b2b_ed", 8'hED, 1'b1, 1'b1, 1'b1, 1'b1, CMD_ENABLE);
    phase_frame("b2b_f4", 8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (ps2_clk_oe === 1'b1 || tx_ready !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL b2b_no_queue: %0d non-idle cycles after frames want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_zero();
    test_nack();
    test_no_device();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded 2 ms");
    $fatal(1);
  end

endmodule
